zero_det_stream_ctrl: RTL and testbench
=======================================

# zero_det_stream_ctrl

Frame controller that sequences the `moore_zero_det` serial detector. Accepts a parallel word on a start pulse and clears the detector. It then shifts the word into the detector LSB-first, one bit per clock, and counts the clocks on which the detector's Moore output equals a configured code. It reports completion with a one-cycle done pulse. It sits between the parallel host side and the detector instance.

## Interface
- `WIDTH`, 8: bits per frame (≥2).
- `CNT_W`, 4: detection counter width.
- `DET_CODE`, 2'b10: detector output value that counts as a detection.

- `clock`  in  1: sole clock, rising-edge.
- `reset`  in  1: asynchronous, active-low reset.
- `start`  in  1: frame request; accepted only in IDLE.
- `data_in`  in  WIDTH: frame word; captured on the accepting edge.
- `det_y_in`  in  2: detector output (`y_out` of the detector).
- `det_x_out`  out  1: serial bit to detector `x_in`.
- `det_rst_n`  out  1: active-low detector clear, low for exactly one cycle per frame.
- `busy`  out  1: frame in progress.
- `done`  out  1: one-cycle completion pulse.
- `det_count`  out  CNT_W: detections in the current/last frame.

## Operation
- All outputs are registered.
- Reset values: `busy`=0, `done`=0, `det_x_out`=1 (idle level), `det_rst_n`=1, `det_count`=0, state IDLE, shift register and bit counter 0.
- States and transitions:
  - IDLE: `busy`=0. If `start`=1, capture `data_in` into the shift register, clear `det_count` and the bit index, and go to CLEAR.
  - CLEAR: `det_rst_n`=0, `det_x_out`=1, `busy`=1. Always go to SHIFT.
  - SHIFT: `det_x_out`=shreg[0]. Shift right by one each cycle and increment the bit index. After the cycle with index WIDTH-1, go to FLUSH.
  - FLUSH: `det_x_out`=1. Always go to DONE.
  - DONE: `done`=1, `busy`=1. Always go to IDLE.
- Detection sampling:
  - Sample `det_y_in` in SHIFT cycles with index ≥1 and in the FLUSH cycle, giving exactly WIDTH samples per frame.
  - Each sample equal to `DET_CODE` increments `det_count`.
- `det_count` saturates at 2^CNT_W−1 with no wrap. It holds its value from DONE until the next accepted start.
- `start` is ignored in CLEAR, SHIFT, FLUSH and DONE. There is no queuing.
- `data_in` changes after the capture edge have no effect on the running frame.
- `reset` asserted in any state forces reset values immediately, independent of the clock. The frame is abandoned and `done` is not issued.

## Timing
- Edge numbering: the edge that samples `start`=1 in IDLE is E0; cycle n is the cycle after edge En−1.
- Cycle 1: CLEAR, with `busy` and the `det_rst_n` low pulse.
- Cycles 2..WIDTH+1: SHIFT, bit i driven on cycle i+2.
- Cycle WIDTH+2: FLUSH.
- Cycle WIDTH+3: DONE, `done`=1. `det_count` is final in this cycle.
- Cycle WIDTH+4: IDLE at the earliest. With `start` held high, a new frame is accepted on the edge ending that cycle, giving a frame period of WIDTH+4 cycles.
- The detector is assumed to have one-cycle Moore latency: the sample taken in cycle k reflects the bit driven in cycle k−1.

## Structure
- Shared package `zero_det_pkg`:
  - state typedef (IDLE, CLEAR, SHIFT, FLUSH, DONE)
  - `X_IDLE_LEVEL`=1'b1
  - default `DET_CODE`
- One natural sub-module: `piso_shift_reg` (WIDTH-bit parallel load, shift-right enable, serial LSB output).
- The FSM, bit counter and saturating detection counter stay in the top level.

## Test plan
- Reset: drive `reset`=0 mid-clock → `busy`=0, `done`=0, `det_x_out`=1, `det_rst_n`=1, `det_count`=0 at once, without waiting for a clock edge.
- Serialisation: WIDTH=8, `data_in`=8'hA5, one-cycle `start` → `det_rst_n` low in cycle 1 only. `det_x_out` in cycles 2..9 = 1,0,1,0,0,1,0,1. `det_x_out`=1 in cycle 10. `done` high only in cycle 11.
- Counting: `det_y_in` tied to 2'b10 → `det_count`=8 in DONE. Tied to 2'b01 → `det_count`=0.
- Saturation: CNT_W=3, `det_y_in`=2'b10 constant → `det_count`=7, with no wrap to 0.
- Back-to-back: `start` held high, `data_in` changed after each capture → `done` pulses every 12 cycles. Each frame serialises its own captured word, and `start` during `busy` causes no restart.
- Mid-frame reset: assert `reset` during SHIFT cycle 5 → all outputs return to reset values with no `done`. After release, a new `start` runs a full 11-cycle frame with a correct count.

Source files
------------

// File: rtl/zero_det_pkg.sv
// Shared types and constants for the zero-detector frame controller.
package zero_det_pkg;

    // Frame sequencing states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        SHIFT = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Level driven on the detector serial input whenever no frame bit is on the wire.
    localparam logic X_IDLE_LEVEL = 1'b1;

    // Default detector output code that counts as a detection.
    localparam logic [1:0] DET_CODE_DEFAULT = 2'b10;

endpackage

// File: rtl/zero_det_stream_ctrl_if.sv
// Host-side and detector-side signals of the frame controller, grouped as one bundle.
interface zero_det_stream_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             start;
    logic [WIDTH-1:0] data_in;
    logic [1:0]       det_y_in;
    logic             det_x_out;
    logic             det_rst_n;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] det_count;

    // Host / environment side: issues frames and returns the detector output.
    modport master (
        output start, data_in, det_y_in,
        input  det_x_out, det_rst_n, busy, done, det_count
    );

    // Controller side.
    modport slave (
        input  start, data_in, det_y_in,
        output det_x_out, det_rst_n, busy, done, det_count
    );
endinterface

// File: rtl/zero_det_stream_ctrl_piso_shift_reg.sv
// Parallel-in serial-out shift register, LSB first, zero fill from the top.
module piso_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] data,
    output logic             ser_out,
    output logic             ser_peek
);
    logic [WIDTH-1:0] shreg;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic bit_reg;
            logic fill;

            if (gi == WIDTH - 1) begin : g_top
                assign fill = 1'b0;
            end else begin : g_mid
                assign fill = shreg[gi + 1];
            end

            // Per-bit storage: load wins over shift, zeros enter at the MSB.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    bit_reg <= 1'b0;
                end else if (load) begin
                    bit_reg <= data[gi];
                end else if (shift_en) begin
                    bit_reg <= fill;
                end
            end

            assign shreg[gi] = bit_reg;
        end
    endgenerate

    // ser_peek is the bit that becomes the LSB after the next shift, so the
    // controller can register the wire value one edge ahead.
    assign ser_out  = shreg[0];
    assign ser_peek = shreg[1];
endmodule

// File: rtl/zero_det_stream_ctrl.sv
// Frame controller: clears the detector, streams a word LSB-first into it,
// and counts cycles on which the detector output matches DET_CODE.
module zero_det_stream_ctrl
    import zero_det_pkg::*;
#(
    parameter int         WIDTH    = 8,
    parameter int         CNT_W    = 4,
    parameter logic [1:0] DET_CODE = DET_CODE_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset,
    zero_det_stream_ctrl_if.slave bus
);
    localparam int               IDX_W    = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic             x_reg, x_next;
    logic             rst_n_reg, rst_n_next;
    logic             load, shift_en, sample;
    logic             sh_lsb, sh_peek;

    piso_shift_reg #(.WIDTH(WIDTH)) u_piso (
        .clock    (clock),
        .reset    (reset),
        .load     (load),
        .shift_en (shift_en),
        .data     (bus.data_in),
        .ser_out  (sh_lsb),
        .ser_peek (sh_peek)
    );

    // Next-state, counters and the next value of every registered output.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        count_next = count_reg;
        load       = 1'b0;
        shift_en   = 1'b0;
        sample     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    load       = 1'b1;
                    idx_next   = '0;
                    count_next = '0;
                    state_next = CLEAR;
                end
            end
            CLEAR: state_next = SHIFT;
            SHIFT: begin
                shift_en = 1'b1;
                // Bit 0's response only shows up one cycle later, so the
                // first SHIFT cycle carries nothing worth sampling.
                sample   = (idx_reg != '0);
                if (idx_reg == IDX_LAST) begin
                    state_next = FLUSH;
                end else begin
                    idx_next = idx_reg + 1'b1;
                end
            end
            FLUSH: begin
                sample     = 1'b1;
                state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        if (sample && (bus.det_y_in == DET_CODE) && (count_reg != CNT_MAX)) begin
            count_next = count_reg + 1'b1;
        end

        busy_next  = (state_next != IDLE);
        done_next  = (state_next == DONE);
        rst_n_next = (state_next != CLEAR);
        x_next     = X_IDLE_LEVEL;
        if (state_next == SHIFT) begin
            // Entering SHIFT the LSB is already loaded; while shifting, the
            // bit that will be the LSB after this edge is one position up.
            x_next = (state_reg == CLEAR) ? sh_lsb : sh_peek;
        end
    end

    // State, counters and output registers with asynchronous clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            count_reg <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            x_reg     <= X_IDLE_LEVEL;
            rst_n_reg <= 1'b1;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            count_reg <= count_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            x_reg     <= x_next;
            rst_n_reg <= rst_n_next;
        end
    end

    assign bus.busy      = busy_reg;
    assign bus.done      = done_reg;
    assign bus.det_x_out = x_reg;
    assign bus.det_rst_n = rst_n_reg;
    assign bus.det_count = count_reg;
endmodule

// File: tb/tb_zero_det_stream_ctrl.sv
// Directed bench for the zero-detector frame controller.
module tb_zero_det_stream_ctrl;
    logic clock;
    logic reset;
    int   n_assert;
    int   n_fail;

    zero_det_stream_ctrl_if #(.WIDTH(8), .CNT_W(4)) bus_a ();
    zero_det_stream_ctrl_if #(.WIDTH(8), .CNT_W(3)) bus_b ();

    zero_det_stream_ctrl #(.WIDTH(8), .CNT_W(4), .DET_CODE(2'b10)) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    zero_det_stream_ctrl #(.WIDTH(8), .CNT_W(3), .DET_CODE(2'b10)) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One full frame on instance A, checked cycle by cycle from the accepting edge.
    task automatic run_frame(input logic [7:0] data, input logic [1:0] y,
                             input logic hold, input logic [7:0] next_data);
        int   exp_cnt;
        logic exp_x;
        bus_a.start    = 1'b1;
        bus_a.data_in  = data;
        bus_a.det_y_in = y;
        tick();
        if (!hold) bus_a.start = 1'b0;
        bus_a.data_in = next_data;
        check("c1_busy",  bus_a.busy,      1);
        check("c1_rst_n", bus_a.det_rst_n, 0);
        check("c1_x",     bus_a.det_x_out, 1);
        check("c1_done",  bus_a.done,      0);
        check("c1_count", bus_a.det_count, 0);
        for (int c = 2; c <= 11; c++) begin
            tick();
            exp_cnt = (y == 2'b10 && c >= 3) ? c - 3 : 0;
            exp_x   = (c <= 9) ? data[c-2] : 1'b1;
            check($sformatf("c%0d_x", c),     bus_a.det_x_out, 32'(exp_x));
            check($sformatf("c%0d_rst_n", c), bus_a.det_rst_n, 1);
            check($sformatf("c%0d_busy", c),  bus_a.busy,      1);
            check($sformatf("c%0d_done", c),  bus_a.done,      (c == 11) ? 1 : 0);
            check($sformatf("c%0d_count", c), bus_a.det_count, 32'(exp_cnt));
        end
        tick();
        check("c12_busy",  bus_a.busy,      0);
        check("c12_done",  bus_a.done,      0);
        check("c12_count", bus_a.det_count, (y == 2'b10) ? 8 : 0);
        $display("frame data=%02h y=%02b hold=%0b done", data, y, hold);
    endtask

    initial begin
        n_assert       = 0;
        n_fail         = 0;
        reset          = 1'b0;
        bus_a.start    = 1'b0;
        bus_a.data_in  = '0;
        bus_a.det_y_in = 2'b00;
        bus_b.start    = 1'b0;
        bus_b.data_in  = '0;
        bus_b.det_y_in = 2'b00;

        // Reset values while reset is held.
        repeat (2) @(posedge clock);
        #1;
        check("rst_busy",    bus_a.busy,      0);
        check("rst_done",    bus_a.done,      0);
        check("rst_x",       bus_a.det_x_out, 1);
        check("rst_rst_n",   bus_a.det_rst_n, 1);
        check("rst_count",   bus_a.det_count, 0);
        check("rst_b_count", bus_b.det_count, 0);
        $display("reset values checked");
        reset = 1'b1;
        tick();

        // Serialisation of A5 with matching detector code, data changed after capture.
        run_frame(8'hA5, 2'b10, 1'b0, 8'h00);
        tick();

        // Non-matching detector code gives zero detections.
        run_frame(8'h96, 2'b01, 1'b0, 8'hFF);
        tick();

        // Back-to-back with start held; each frame must use its own captured word.
        run_frame(8'h3C, 2'b10, 1'b1, 8'hC3);
        run_frame(8'hC3, 2'b01, 1'b1, 8'h0F);
        run_frame(8'h0F, 2'b10, 1'b0, 8'hFF);
        tick();

        // Mid-frame asynchronous reset during SHIFT cycle 5.
        bus_a.start    = 1'b1;
        bus_a.data_in  = 8'hA5;
        bus_a.det_y_in = 2'b10;
        tick();
        bus_a.start = 1'b0;
        repeat (4) tick();
        check("mid_busy_before", bus_a.busy, 1);
        #3;
        reset = 1'b0;
        #1;
        check("mid_busy",  bus_a.busy,      0);
        check("mid_done",  bus_a.done,      0);
        check("mid_x",     bus_a.det_x_out, 1);
        check("mid_rst_n", bus_a.det_rst_n, 1);
        check("mid_count", bus_a.det_count, 0);
        tick();
        check("mid_hold_done", bus_a.done, 0);
        check("mid_hold_busy", bus_a.busy, 0);
        $display("mid-frame reset checked");
        reset = 1'b1;
        tick();
        check("post_rst_done", bus_a.done, 0);
        run_frame(8'hA5, 2'b10, 1'b0, 8'h5A);

        // Saturation on the 3-bit counter instance.
        bus_b.start    = 1'b1;
        bus_b.data_in  = 8'h5A;
        bus_b.det_y_in = 2'b10;
        tick();
        bus_b.start = 1'b0;
        check("sat_c1_busy", bus_b.busy, 1);
        for (int c = 2; c <= 12; c++) begin
            tick();
            if (c == 9)  check("sat_c9_count",  bus_b.det_count, 6);
            if (c == 10) check("sat_c10_count", bus_b.det_count, 7);
            if (c == 11) begin
                check("sat_c11_count", bus_b.det_count, 7);
                check("sat_c11_done",  bus_b.done,      1);
            end
            if (c == 12) begin
                check("sat_c12_count", bus_b.det_count, 7);
                check("sat_c12_busy",  bus_b.busy,      0);
            end
        end
        $display("saturation frame done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
